// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fetch_unit_pkg                                              |
// | Brief  : Shared types and constants for the instruction fetch stage  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FetchIdle = 2'd0,
      FetchReq  = 2'd1,
      FetchWait = 2'd2
   } fetch_state_e;

   // addi x0, x0, 0 : what decode sees before the first real fetch
   localparam logic [31:0] InstrNop = 32'h0000_0013;

   // RV32I instruction addresses must be word aligned
   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_program_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : program_counter                                             |
// | Brief  : Fetch PC register, +4 incrementer, deferred redirect target |
// |          and redirect alignment check                                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module program_counter
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_in_flight,   // a transaction is outstanding
   input  logic            i_pc_load,
   input  logic [XLEN-1:0] i_pc_target,
   input  logic            i_advance,     // normal completion: step to next word
   input  logic            i_commit,      // redirected completion: take target
   output logic [XLEN-1:0] o_fetch_pc,
   output logic            o_pending,
   output logic            o_load_ok,
   output logic            o_load_bad,
   output logic            o_misaligned
);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
   logic            pending_q, pending_d;
   logic            misaligned_q, misaligned_d;
   logic            w_aligned;

   assign w_aligned  = is_aligned(i_pc_target[1:0]);
   assign o_load_ok  = i_pc_load & w_aligned;
   assign o_load_bad = i_pc_load & ~w_aligned;

   // Next PC selection; a redirect seen in the same cycle as completion wins
   // over an older pending target because it is the most recent one.
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      pend_tgt_d   = pend_tgt_q;
      pending_d    = pending_q;
      misaligned_d = o_load_bad;
      if (i_commit) begin
         fetch_pc_d = o_load_ok ? i_pc_target : pend_tgt_q;
         pending_d  = 1'b0;
      end else if (i_advance) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end else if (o_load_ok) begin
         if (i_in_flight) begin
            pending_d  = 1'b1;
            pend_tgt_d = i_pc_target;
         end else begin
            fetch_pc_d = i_pc_target;
         end
      end
   end

   // PC state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc_q   <= RESET_VECTOR;
         pend_tgt_q   <= RESET_VECTOR;
         pending_q    <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pend_tgt_q   <= pend_tgt_d;
         pending_q    <= pending_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign o_fetch_pc   = fetch_pc_q;
   assign o_pending    = pending_q;
   assign o_misaligned = misaligned_q;

endmodule : program_counter
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fetch_unit                                                  |
// | Brief  : RV32I fetch stage: one valid/ready imem fetch per request,  |
// |          single-cycle decode enable, deferred branch redirects       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              ILEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_fetch_en,
   input  logic            i_pc_load,
   input  logic [XLEN-1:0] i_pc_target,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_rsp_valid,
   input  logic [ILEN-1:0] i_imem_rdata,
   output logic [ILEN-1:0] o_instruction,
   output logic            o_decode_en,
   output logic [XLEN-1:0] o_pc,
   output logic            o_busy,
   output logic            o_misaligned
);

   fetch_state_e    state_q, state_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] opc_q, opc_d;
   logic            dec_q, dec_d;

   logic [XLEN-1:0] w_fetch_pc;
   logic            w_pending, w_load_ok, w_load_bad;
   logic            w_rsp_done, w_redirect, w_advance;

   assign w_rsp_done = (state_q == FetchWait) & i_imem_rsp_valid;
   assign w_redirect = w_rsp_done & (w_pending | w_load_ok);
   assign w_advance  = w_rsp_done & ~w_redirect;

   program_counter #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .clk          (clk),
      .rstn         (rstn),
      .i_in_flight  (state_q != FetchIdle),
      .i_pc_load    (i_pc_load),
      .i_pc_target  (i_pc_target),
      .i_advance    (w_advance),
      .i_commit     (w_redirect),
      .o_fetch_pc   (w_fetch_pc),
      .o_pending    (w_pending),
      .o_load_ok    (w_load_ok),
      .o_load_bad   (w_load_bad),
      .o_misaligned (o_misaligned)
   );

   // Fetch sequencing; a redirected response is discarded and the target
   // is requested straight away without waiting for another fetch enable.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      dec_d   = 1'b0;
      case (state_q)
         FetchIdle: if (i_fetch_en && !w_load_bad) state_d = FetchReq;
         FetchReq:  if (i_imem_req_ready) state_d = FetchWait;
         FetchWait: begin
            if (w_redirect) begin
               state_d = FetchReq;
            end else if (w_advance) begin
               instr_d = i_imem_rdata;
               opc_d   = w_fetch_pc;
               dec_d   = 1'b1;
               state_d = FetchIdle;
            end
         end
         default:   state_d = FetchIdle;
      endcase
   end

   // State and decode-side output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= FetchIdle;
         instr_q <= ILEN'(InstrNop);
         opc_q   <= RESET_VECTOR;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
         dec_q   <= dec_d;
      end
   end

   assign o_imem_req_valid = (state_q == FetchReq);
   assign o_imem_addr      = w_fetch_pc;
   assign o_instruction    = instr_q;
   assign o_decode_en      = dec_q;
   assign o_pc             = opc_q;
   assign o_busy           = (state_q != FetchIdle);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_fetch_unit                                               |
// | Brief  : Self-checking bench for fetch_unit: directed scenarios plus |
// |          randomized traffic against a transaction-level model        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   logic        clk;
   logic        rstn;
   logic        i_fetch_en, i_pc_load, i_imem_req_ready, i_imem_rsp_valid;
   logic [31:0] i_pc_target, i_imem_rdata;
   logic        o_imem_req_valid, o_decode_en, o_busy, o_misaligned;
   logic [31:0] o_imem_addr, o_instruction, o_pc;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: phase 0 = idle, 1 = requesting, 2 = awaiting data
   int          m_phase;
   logic [31:0] m_pc, m_ptgt, m_instr, m_opc;
   bit          m_pend, m_dec, m_mis;

   fetch_unit #(
      .XLEN             (32),
      .ILEN             (32),
      .RESET_VECTOR     (RESET_VECTOR)
   ) dut (
      .clk              (clk),
      .rstn             (rstn),
      .i_fetch_en       (i_fetch_en),
      .i_pc_load        (i_pc_load),
      .i_pc_target      (i_pc_target),
      .o_imem_req_valid (o_imem_req_valid),
      .i_imem_req_ready (i_imem_req_ready),
      .o_imem_addr      (o_imem_addr),
      .i_imem_rsp_valid (i_imem_rsp_valid),
      .i_imem_rdata     (i_imem_rdata),
      .o_instruction    (o_instruction),
      .o_decode_en      (o_decode_en),
      .o_pc             (o_pc),
      .o_busy           (o_busy),
      .o_misaligned     (o_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_pc    = RESET_VECTOR;
      m_ptgt  = RESET_VECTOR;
      m_pend  = 0;
      m_instr = 32'h0000_0013;
      m_opc   = RESET_VECTOR;
      m_dec   = 0;
      m_mis   = 0;
   endtask

   // one clock edge of the fetch stage, expressed as the behavioural rules
   task automatic model_step(input bit fe, input bit ld, input logic [31:0] tgt,
                             input bit rdy, input bit rv, input logic [31:0] rd);
      bit good_ld, bad_ld;
      good_ld = ld && (tgt % 4 == 0);
      bad_ld  = ld && (tgt % 4 != 0);
      m_dec   = 0;
      m_mis   = bad_ld;
      if (m_phase == 0) begin
         if (good_ld) m_pc = tgt;
         if (fe && !bad_ld) m_phase = 1;
      end else if (m_phase == 2 && rv) begin
         if (m_pend || good_ld) begin
            m_pc    = good_ld ? tgt : m_ptgt;
            m_pend  = 0;
            m_phase = 1;
         end else begin
            m_instr = rd;
            m_opc   = m_pc;
            m_pc    = m_pc + 32'd4;
            m_dec   = 1;
            m_phase = 0;
         end
      end else begin
         if (good_ld) begin
            m_pend = 1;
            m_ptgt = tgt;
         end
         if (m_phase == 1 && rdy) m_phase = 2;
      end
   endtask

   task automatic compare_all();
      check("decode_en",   {31'd0, o_decode_en},      {31'd0, m_dec});
      check("instruction", o_instruction,             m_instr);
      check("o_pc",        o_pc,                      m_opc);
      check("req_valid",   {31'd0, o_imem_req_valid}, {31'd0, m_phase == 1});
      check("imem_addr",   o_imem_addr,               m_pc);
      check("busy",        {31'd0, o_busy},           {31'd0, m_phase != 0});
      check("misaligned",  {31'd0, o_misaligned},     {31'd0, m_mis});
   endtask

   task automatic cycle(input bit fe, input bit ld, input logic [31:0] tgt,
                        input bit rdy, input bit rv, input logic [31:0] rd);
      @(negedge clk);
      i_fetch_en       = fe;
      i_pc_load        = ld;
      i_pc_target      = tgt;
      i_imem_req_ready = rdy;
      i_imem_rsp_valid = rv;
      i_imem_rdata     = rd;
      model_step(fe, ld, tgt, rdy, rv, rd);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      i_fetch_en       = 0;
      i_pc_load        = 0;
      i_pc_target      = 0;
      i_imem_req_ready = 0;
      i_imem_rsp_valid = 0;
      i_imem_rdata     = 0;
   endtask

   // asynchronous reset asserted between clock edges
   task automatic do_reset();
      @(negedge clk);
      rstn = 0;
      idle_inputs();
      #1;
      model_reset();
      compare_all();
      check("rst_pc",    o_pc,          RESET_VECTOR);
      check("rst_instr", o_instruction, 32'h0000_0013);
      @(negedge clk);
      rstn = 1;
      model_step(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      logic [31:0] tgt;
      bit          rv;
      rstn = 1;
      idle_inputs();
      model_reset();
      #1 rstn = 0;

      // 1: reset state
      #20;
      check("t1_pc",       o_pc,                      32'h0);
      check("t1_instr",    o_instruction,             32'h0000_0013);
      check("t1_decode",   {31'd0, o_decode_en},      32'd0);
      check("t1_reqvalid", {31'd0, o_imem_req_valid}, 32'd0);
      check("t1_misalign", {31'd0, o_misaligned},     32'd0);
      check("t1_busy",     {31'd0, o_busy},           32'd0);
      @(negedge clk);
      rstn = 1;

      // 2: zero-wait fetch
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h0050_0093);
      check("t2_decode", {31'd0, o_decode_en}, 32'd1);
      check("t2_instr",  o_instruction,        32'h0050_0093);
      check("t2_pc",     o_pc,                 32'h0);
      cycle(0, 0, 0, 0, 0, 0);
      check("t2_decode_drop", {31'd0, o_decode_en}, 32'd0);
      check("t2_next_addr",   o_imem_addr,          32'h4);

      // 3: ready held low for three cycles
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         check("t3_req_held",  {31'd0, o_imem_req_valid}, 32'd1);
         check("t3_addr_held", o_imem_addr,               32'h4);
      end
      cycle(0, 0, 0, 1, 0, 0);
      check("t3_wait_entered", {31'd0, o_imem_req_valid}, 32'd0);
      cycle(0, 0, 0, 0, 1, 32'h1111_2222);

      // 4: redirect while waiting drops the response
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 1, 32'h100, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      check("t4_no_decode", {31'd0, o_decode_en},      32'd0);
      check("t4_instr",     o_instruction,             32'h1111_2222);
      check("t4_req",       {31'd0, o_imem_req_valid}, 32'd1);
      check("t4_addr",      o_imem_addr,               32'h100);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h0000_0033);
      check("t4_pc", o_pc, 32'h100);

      // 5: misaligned redirect in idle
      cycle(0, 1, 32'h102, 0, 0, 0);
      check("t5_misaligned", {31'd0, o_misaligned}, 32'd1);
      check("t5_addr",       o_imem_addr,           32'h104);
      cycle(0, 0, 0, 0, 0, 0);
      check("t5_pulse_end", {31'd0, o_misaligned}, 32'd0);

      // 6: wrap of the fetch PC
      cycle(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
      check("t6_req_addr", o_imem_addr, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h0000_0013);
      check("t6_pc",   o_pc,        32'hFFFF_FFFC);
      check("t6_wrap", o_imem_addr, 32'h0);

      // 7: reset in the middle of a transaction, then a late response
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      do_reset();
      cycle(0, 0, 0, 0, 1, 32'hCAFE_F00D);
      check("t7_no_decode", {31'd0, o_decode_en}, 32'd0);
      check("t7_addr",      o_imem_addr,          RESET_VECTOR);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         tgt = $urandom;
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         if (m_phase == 2)      rv = $urandom_range(0, 1) == 1;
         else if (m_phase == 0) rv = $urandom_range(0, 9) == 0;
         else                   rv = 0;
         if (n == 300) do_reset();
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, tgt,
               $urandom_range(0, 1) == 1, rv, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
